// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_scan_decoder                                                |
// | Brief   : Captures debounced dwells of a scanned active-low 7-seg bus and  |
// |           decodes each digit back to a hex nibble, flagging bad patterns.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [7:0]            seg_n,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  all_valid,
    output logic                  invalid_pulse,
    output logic                  frame_valid,
    output logic [7:0]            err_count
);

    localparam logic [7:0] c_stable    = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_stable_m1 = 8'(STABLE_CYCLES - 1);

    logic [DIGITS-1:0] r_samp_an;
    logic [7:0]        r_samp_seg;
    logic [7:0]        r_cnt;
    logic [DIGITS-1:0] r_seen;
    logic              r_invalid;
    logic              r_frame;
    logic [7:0]        r_err;

    logic              w_match;
    logic [DIGITS-1:0] w_low;
    logic              w_onehot;
    logic              w_capture;
    logic              w_legal;
    logic [3:0]        w_nib;
    logic [DIGITS-1:0] w_seen_next;

    // Returns {legal, nibble} for a..g (active low, a in the MSB).
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001111: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0000100: decode = {1'b1, 4'h9};
            7'b0001100: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b1100000: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    assign w_match     = (an_n == r_samp_an) && (seg_n == r_samp_seg);
    assign w_low       = ~r_samp_an;
    assign w_onehot    = (w_low != '0) && ((w_low & (w_low - DIGITS'(1))) == '0);
    // Firing only on the cnt == STABLE-1 step gives one capture per dwell.
    assign w_capture   = w_match && (r_cnt == c_stable_m1) && w_onehot;
    assign {w_legal, w_nib} = decode(r_samp_seg[7:1]);
    assign w_seen_next = r_seen | w_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp_an  <= '1;
            r_samp_seg <= 8'hFF;
            r_cnt      <= 8'd0;
        end else begin
            r_samp_an  <= an_n;
            r_samp_seg <= seg_n;
            if (!w_match) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != c_stable) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen    <= '0;
            r_invalid <= 1'b0;
            r_frame   <= 1'b0;
            r_err     <= 8'd0;
        end else if (clear) begin
            r_seen    <= '0;
            r_invalid <= 1'b0;
            r_frame   <= 1'b0;
            r_err     <= 8'd0;
        end else begin
            r_invalid <= 1'b0;
            r_frame   <= 1'b0;
            if (w_capture) begin
                if (w_seen_next == '1) begin
                    r_frame <= 1'b1;
                    r_seen  <= '0;
                end else begin
                    r_seen  <= w_seen_next;
                end
                if (!w_legal) begin
                    r_invalid <= 1'b1;
                    if (r_err != 8'hFF) begin
                        r_err <= r_err + 8'd1;
                    end
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] r_nib;
            logic       r_dp;
            logic       r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_nib   <= 4'h0;
                    r_dp    <= 1'b0;
                    r_valid <= 1'b0;
                end else if (clear) begin
                    r_valid <= 1'b0;
                end else if (w_capture && w_low[k]) begin
                    r_dp    <= ~r_samp_seg[0];
                    r_valid <= w_legal;
                    if (w_legal) begin
                        r_nib <= w_nib;
                    end
                end
            end

            assign digits_out[4*k +: 4] = r_nib;
            assign dp_out[k]            = r_dp;
            assign digit_valid[k]       = r_valid;
        end
    endgenerate

    assign all_valid     = &digit_valid;
    assign invalid_pulse = r_invalid;
    assign frame_valid   = r_frame;
    assign err_count     = r_err;

endmodule
`default_nettype wire
